// File: rtl/seg_pkg.sv
// Shared constants for the hex display controller: glyph table, blank pattern
// and the channel-select width helper.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low gfedcba glyphs, entry 15 leftmost so GLYPH_TBL[n] is nibble n.
    localparam logic [15:0][6:0] GLYPH_TBL = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic int calc_csw(input int nch);
        return (nch <= 1) ? 1 : $clog2(nch);
    endfunction

endpackage

// File: rtl/seg_disp_mux_hex_to_seg7.sv
// Nibble to active-low seven-segment glyph, with a force-blank override.
module hex_to_seg7
    import seg_pkg::*;
(
    input  logic [3:0] nib_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    assign seg_o = blank_i ? SEG_BLANK : GLYPH_TBL[nib_i];

endmodule

// File: rtl/seg_disp_mux.sv
// Channel snapshot, hex decode with leading-zero blanking, and registered
// static plus time-multiplexed segment outputs.
module seg_disp_mux
    import seg_pkg::*;
#(
    parameter int BW       = 16,
    parameter int NCH      = 2,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 5000,
    parameter int CSW      = calc_csw(NCH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH*BW-1:0]     ch_data,
    input  logic [CSW-1:0]        ch_sel,
    input  logic                  hold,
    input  logic                  load,
    input  logic                  lz_en,
    output logic [7*DIGITS-1:0]   seg_static,
    output logic [6:0]            seg_scan,
    output logic [DIGITS-1:0]     an,
    output logic [BW-1:0]         snap
);

    localparam int PW  = DIGITS * 4;
    localparam int PSW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [BW-1:0]       snap_q, snap_d, chan_w;
    logic [PW-1:0]       snap_ext;
    logic [DIGITS-1:0]   blank_w;
    logic [7*DIGITS-1:0] seg_static_q, seg_static_d;
    logic [6:0]          seg_scan_q, seg_scan_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [PSW-1:0]      pre_q, pre_d;
    logic [DW-1:0]       dig_q, dig_d;

    // Out-of-range selects fall through to channel 0.
    always_comb begin
        chan_w = ch_data[BW-1:0];
        for (int k = 1; k < NCH; k++) begin
            if (ch_sel == CSW'(k)) chan_w = ch_data[k*BW +: BW];
        end
    end

    assign snap_d = (!hold || load) ? chan_w : snap_q;

    always_comb begin
        snap_ext = '0;
        snap_ext[BW-1:0] = snap_q;
    end

    // Walk down from the MSB digit; digit 0 is never blanked.
    always_comb begin
        logic seen;
        seen    = 1'b0;
        blank_w = '0;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            if (snap_ext[4*d +: 4] != 4'h0) seen = 1'b1;
            blank_w[d] = lz_en && !seen;
        end
    end

    for (genvar d = 0; d < DIGITS; d++) begin : g_dec
        hex_to_seg7 u_dec (
            .nib_i   (snap_ext[4*d +: 4]),
            .blank_i (blank_w[d]),
            .seg_o   (seg_static_d[7*d +: 7])
        );
    end

    always_comb begin
        pre_d = pre_q + PSW'(1);
        dig_d = dig_q;
        if (pre_q == PSW'(SCAN_DIV - 1)) begin
            pre_d = '0;
            dig_d = (dig_q == DW'(DIGITS - 1)) ? '0 : dig_q + DW'(1);
        end
    end

    // Anode and segments both follow dig_q so they always switch together.
    assign an_d       = ~(DIGITS'(1) << dig_q);
    assign seg_scan_d = seg_static_q[7*dig_q +: 7];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_q       <= '0;
            seg_static_q <= '1;
            seg_scan_q   <= SEG_BLANK;
            an_q         <= '1;
            pre_q        <= '0;
            dig_q        <= '0;
        end else begin
            snap_q       <= snap_d;
            seg_static_q <= seg_static_d;
            seg_scan_q   <= seg_scan_d;
            an_q         <= an_d;
            pre_q        <= pre_d;
            dig_q        <= dig_d;
        end
    end

    assign snap       = snap_q;
    assign seg_static = seg_static_q;
    assign seg_scan   = seg_scan_q;
    assign an         = an_q;

endmodule

// File: tb/tb_seg_disp_mux.sv
// Scoreboard bench for seg_disp_mux: a cycle-level reference model predicts
// every output, a monitor compares after each rising edge.
module tb_seg_disp_mux;

    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [47:0] ch_data = '0;
    logic [1:0]  ch_sel = '0;
    logic        hold = 1'b0, load = 1'b0, lz_en = 1'b0;
    logic [27:0] seg_static;
    logic [6:0]  seg_scan;
    logic [3:0]  an;
    logic [15:0] snap;

    int checks = 0;
    int failures = 0;

    seg_disp_mux #(.BW(16), .NCH(3), .DIGITS(4), .SCAN_DIV(SD)) dut (
        .clk(clk), .rst(rst), .ch_data(ch_data), .ch_sel(ch_sel),
        .hold(hold), .load(load), .lz_en(lz_en),
        .seg_static(seg_static), .seg_scan(seg_scan), .an(an), .snap(snap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] snap;
        logic [27:0] stat;
        logic [6:0]  scan;
        logic [3:0]  an;
    } exp_t;

    exp_t q[$];

    // Model state: values the outputs hold after the most recent edge.
    logic [15:0] m_snap = '0;
    logic [27:0] m_stat = '1;
    int          n_edges = 0;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [27:0] decode(input logic [15:0] v, input logic lz);
        logic [27:0] r;
        int msd;
        msd = 0;
        for (int d = 0; d < 4; d++) if (v[4*d +: 4] != 4'h0) msd = d;
        for (int d = 0; d < 4; d++)
            r[7*d +: 7] = (lz && d > msd) ? 7'h7F : glyph(v[4*d +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] chan(input logic [47:0] c, input logic [1:0] s);
        case (s)
            2'd1: return c[31:16];
            2'd2: return c[47:32];
            default: return c[15:0];
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_reset();
        exp_t e;
        m_snap  = '0;
        m_stat  = '1;
        n_edges = 0;
        e.snap = '0; e.stat = '1; e.scan = 7'h7F; e.an = 4'hF;
        q.push_back(e);
    endtask

    // Drive inputs for the next edge and predict what that edge produces.
    task automatic step(input logic r, input logic [47:0] c, input logic [1:0] s,
                        input logic h, input logic l, input logic lz);
        exp_t e;
        int dig;
        @(negedge clk);
        rst = r; ch_data = c; ch_sel = s; hold = h; load = l; lz_en = lz;
        if (r) begin
            push_reset();
        end else begin
            n_edges++;
            dig    = ((n_edges - 1) / SD) % 4;
            e.scan = m_stat[7*dig +: 7];
            e.an   = ~(4'b0001 << dig);
            e.stat = decode(m_snap, lz);
            e.snap = (!h || l) ? chan(c, s) : m_snap;
            m_snap = e.snap;
            m_stat = e.stat;
            q.push_back(e);
        end
    endtask

    task automatic mid_reset();
        @(negedge clk);
        push_reset();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_snap", 32'(snap), 32'h0);
        chk("async_rst_static", 32'(seg_static), 32'h0FFFFFFF);
        chk("async_rst_scan", 32'(seg_scan), 32'h7F);
        chk("async_rst_an", 32'(an), 32'hF);
    endtask

    task automatic post_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("snap", 32'(snap), 32'(e.snap));
                chk("seg_static", 32'(seg_static), 32'(e.stat));
                chk("seg_scan", 32'(seg_scan), 32'(e.scan));
                chk("an", 32'(an), 32'(e.an));
            end
        end
    end

    initial begin : driver
        logic [47:0] c;
        for (int i = 0; i < 3; i++) step(1'b1, '0, 2'd0, 1'b0, 1'b0, 1'b0);

        c = {16'h0000, 16'h0000, 16'h1A2F};
        for (int i = 0; i < 3; i++) step(1'b0, c, 2'd0, 1'b0, 1'b0, 1'b0);
        post_edge();
        chk("static_1A2F", 32'(seg_static), 32'({7'b1111001, 7'b0001000, 7'b0100100, 7'b0001110}));

        c = {32'h0, 16'h0005};
        for (int i = 0; i < 2; i++) step(1'b0, c, 2'd0, 1'b0, 1'b0, 1'b1);
        post_edge();
        chk("blank_0005", 32'(seg_static), 32'({7'h7F, 7'h7F, 7'h7F, 7'b0010010}));
        c = '0;
        for (int i = 0; i < 2; i++) step(1'b0, c, 2'd0, 1'b0, 1'b0, 1'b1);
        post_edge();
        chk("blank_zero", 32'(seg_static), 32'({7'h7F, 7'h7F, 7'h7F, 7'b1000000}));

        c = {32'h0, 16'h1234};
        for (int i = 0; i < 2; i++) step(1'b0, c, 2'd0, 1'b0, 1'b0, 1'b0);
        c = {32'h0, 16'hBEEF};
        for (int i = 0; i < 3; i++) step(1'b0, c, 2'd0, 1'b1, 1'b0, 1'b0);
        post_edge();
        chk("hold_keeps", 32'(snap), 32'h1234);
        step(1'b0, c, 2'd0, 1'b1, 1'b1, 1'b0);
        post_edge();
        chk("load_captures", 32'(snap), 32'hBEEF);
        step(1'b0, c, 2'd0, 1'b1, 1'b0, 1'b0);

        c = {16'hC0DE, 16'h5555, 16'h7777};
        step(1'b0, c, 2'd3, 1'b0, 1'b0, 1'b0);
        post_edge();
        chk("sel3_is_ch0", 32'(snap), 32'h7777);
        step(1'b0, c, 2'd2, 1'b0, 1'b0, 1'b0);
        post_edge();
        chk("sel2_is_ch2", 32'(snap), 32'hC0DE);

        c = {32'h0, 16'h1234};
        for (int i = 0; i < 22; i++) step(1'b0, c, 2'd0, 1'b0, 1'b0, 1'b0);
        mid_reset();
        step(1'b1, c, 2'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, c, 2'd0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            c = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) c[15:4] = '0;
            if ($urandom_range(0, 150) == 0) mid_reset();
            step(($urandom_range(0, 120) == 0), c, 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                 1'($urandom));
        end
        step(1'b0, c, 2'd0, 1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        if (q.size() != 0) chk("queue_drained", 32'(q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_disp_mux.md
# seg_disp_mux

Parametrised hex display controller that replaces the fixed four-instance seven-segment hookup at the CPU top. It selects one of NCH register channels and snapshots it, with optional hold/one-shot capture. It decodes the snapshot to DIGITS hex digits with optional leading-zero blanking. It drives either static per-digit segment buses or a time-multiplexed single segment bus with digit anodes.

## Interface
- BW, 16, width of each channel word; DIGITS*4 >= BW required, upper digits zero-extended
- NCH, 2, number of input channels (>= 1)
- DIGITS, 4, number of hex digits displayed
- SCAN_DIV, 5000, clk cycles per digit in scan mode (>= 2)
- CSW, derived max(1, clog2(NCH)), width of ch_sel
- clk  in  1  system clock; the only clock
- rst  in  1  asynchronous, active-high reset
- ch_data  in  NCH*BW  packed channels, channel k at [k*BW +: BW]
- ch_sel  in  CSW  channel select; values >= NCH select channel 0
- hold  in  1  1 = freeze snapshot
- load  in  1  single-cycle capture request, honoured only while hold=1
- lz_en  in  1  1 = blank leading zero digits
- seg_static  out  7*DIGITS  active-low segments, digit d at [7*d +: 7], bit order gfedcba
- seg_scan  out  7  active-low segments of the currently scanned digit
- an  out  DIGITS  active-low one-hot digit enable for scan mode
- snap  out  BW  current snapshot value

## Operation
- Snapshot: if hold=0, snap <= selected channel every cycle; if hold=1 and load=1, snap <= selected channel once; if hold=1 and load=0, snap is retained.
- Decode: each nibble maps to standard hex glyphs, active-low. Examples: 0 = 1000000, 1 = 1111001, 8 = 0000000, A = 0001000, F = 0001110. Blank = 1111111.
- Leading-zero blanking with lz_en=1: every digit above the most significant nonzero nibble is blank. Digit 0 is always shown, so snap=0 shows a single "0". With lz_en=0, all digits are shown.
- Scan: prescaler counts 0..SCAN_DIV-1. At the terminal count it wraps to 0 and the digit index advances d -> (d+1) mod DIGITS. an has bit d low and all others high. seg_scan carries the glyph of digit d, including blanking.
- Scan and static outputs are always both live; the board wiring decides which is used.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Reset values: snap=0, seg_static all 1s, seg_scan=1111111, an all 1s, prescaler=0, digit index=0.
- Latency: ch_data/ch_sel -> snap is 1 cycle; snap -> seg_static is 1 cycle, so the total is 2 cycles.
- Scan: in the first scan period after reset release, an = ~1 (digit 0) from the first clock edge. Thereafter, an and seg_scan change on the same edge, exactly every SCAN_DIV cycles. Both are registered together, so there is no cycle of mismatched anode/segment.
- seg_scan reflects the seg_static value of the selected digit registered on the same edge, i.e. 1 cycle behind seg_static.
- load with hold=0 is ignored, because capture is already continuous. load held high over several cycles with hold=1 captures on every such cycle.
- A hold rising edge freezes the value captured on that same edge's preceding cycle, with no extra capture.
- Asynchronous reset mid-scan immediately forces the reset values. The scan restarts at digit 0 with a full SCAN_DIV period.
- A change of lz_en takes effect on seg_static after 1 cycle.

## Structure
- Shared package seg_pkg holds the 16-entry glyph constant table, SEG_BLANK = 7'h7F, and the function computing CSW.
- Sub-module hex_to_seg7: combinational nibble + blank flag -> 7-bit glyph. It is instantiated DIGITS times in a generate loop, plus scan selection from the registered seg_static.
- The top holds the snapshot register, leading-zero mask logic (priority scan from the MSB digit), prescaler, digit counter, and output registers.

## Test plan
- Reset: assert rst mid-run with SCAN_DIV=4 -> all outputs immediately go to reset values. After release, an = 1110 for 4 cycles, then 1101.
- Static decode: BW=16, NCH=2, ch_data={16'h0000,16'h1A2F}, ch_sel=0, lz_en=0 -> after 2 cycles seg_static digits 3..0 = 1111001, 0001000, 0100100, 0001110.
- Blanking: snap=16'h0005, lz_en=1 -> digits 3..1 = 1111111, digit 0 = 0010010. snap=0 -> only digit 0 = 1000000.
- Hold/load: hold=1 with snap=16'h1234, then change the channel to 16'hBEEF -> snap stays 1234. A one-cycle load -> snap=BEEF next cycle.
- Channel select: NCH=3, ch_sel=3 -> channel 0 value appears. ch_sel=2 -> channel 2 value appears.
- Scan sequence: SCAN_DIV=4, snap=16'h1234 -> an cycles 1110, 1101, 1011, 0111, 1110 every 4 cycles. seg_scan = glyphs 4, 3, 2, 1 in lockstep with an.
